// File: rtl/xgmac_rx_client_emu_pkg.sv
// Shared types for the xgmac RX client emulator: the stored word layout, the read FSM states
// and the byte-enable contiguity check.
package xgmac_rx_client_emu_pkg;

   // The err and last flags sit above strb and data in each 74-bit store word.
   typedef struct packed {
      logic        err;
      logic        last;
      logic [7:0]  strb;
      logic [63:0] data;
   } rx_word_t;

   localparam int C_WORD_W = $bits(rx_word_t);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_STATUS = 2'd2,
      ST_IFG    = 2'd3
   } rd_state_t;

   // True when strb has the form 2**k-1, meaning its set bits run unbroken up from bit 0.
   function automatic logic strb_contiguous(input logic [7:0] strb);
      logic [7:0] plus_one;
      plus_one = strb + 8'd1;
      return (strb & plus_one) == 8'h00;
   endfunction

endpackage

// File: rtl/xgmac_rx_client_emu_if.sv
// Stream-side and MAC-client-side signals of the RX client emulator.
// The emulator uses the slave modport. The upstream stream source and the MAC client consumer use the master modport.
interface xgmac_rx_client_emu_if;

   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tstrb;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic        s_axis_err_tvalid;

   logic [63:0] rx_data;
   logic [7:0]  rx_data_valid;
   logic        rx_good_frame;
   logic        rx_bad_frame;

   modport slave (
      input  s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast, s_axis_err_tvalid,
      output s_axis_tready, rx_data, rx_data_valid, rx_good_frame, rx_bad_frame
   );

   modport master (
      output s_axis_tdata, s_axis_tstrb, s_axis_tvalid, s_axis_tlast, s_axis_err_tvalid,
      input  s_axis_tready, rx_data, rx_data_valid, rx_good_frame, rx_bad_frame
   );

endinterface

// File: rtl/xgmac_rx_client_emu_ram.sv
// Simple dual-port frame store: one write port and one read port, with a registered read.
module xgmac_rx_emu_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 74
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/xgmac_rx_client_emu.sv
// Store-and-forward bridge from an AXI4-Stream packet stream to the xgmac RX client interface.
// A frame is replayed without gaps only after it has been received completely.
module xgmac_rx_client_emu
   import xgmac_rx_client_emu_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH = 64,
   parameter int C_FIFO_DEPTH_LOG2   = 9,
   parameter int C_IFG_CYCLES        = 3
) (
   input  logic                 axi_aclk,
   input  logic                 axi_resetn,
   xgmac_rx_client_emu_if.slave bus,
   output logic [15:0]          drop_count
);

   localparam int          AW       = C_FIFO_DEPTH_LOG2;
   localparam logic [AW:0] DEPTH    = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [15:0] IFG_LAST = (C_IFG_CYCLES >= 2) ? 16'(C_IFG_CYCLES - 2) : 16'd0;

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] frame_start;
   logic [AW:0] frame_count;
   logic        dropping_q;
   logic        err_acc;
   logic        ready_en;
   logic        full;
   logic        drop_active;
   logic        accept;
   logic        wr_en;
   logic        beat_err;
   logic        frame_err;
   logic        frame_inc;
   logic        frame_dec;
   logic        rd_en;
   rx_word_t    wr_word;
   rx_word_t    rd_word;

   rd_state_t   state;
   rd_state_t   state_n;
   logic [15:0] ifg_cnt;
   logic [15:0] ifg_n;
   logic [63:0] rx_data_q;
   logic [63:0] rx_data_n;
   logic [7:0]  rx_valid_q;
   logic [7:0]  rx_valid_n;
   logic        good_q;
   logic        good_n;
   logic        bad_q;
   logic        bad_n;

   xgmac_rx_emu_ram #(
      .ADDR_W (AW),
      .DATA_W (C_WORD_W)
   ) u_ram (
      .clk     (axi_aclk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_word),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_word)
   );

   // A full store with no complete frame holds only an oversized frame, so that frame is dropped.
   assign full        = (wr_ptr - rd_ptr) == DEPTH;
   assign drop_active = dropping_q | (full & (frame_count == '0));
   assign bus.s_axis_tready = ready_en & (!full | drop_active);
   assign accept      = bus.s_axis_tvalid & bus.s_axis_tready;
   assign wr_en       = accept & !drop_active;
   assign frame_inc   = wr_en & bus.s_axis_tlast;

   assign beat_err  = !strb_contiguous(bus.s_axis_tstrb) |
                      (bus.s_axis_tlast ? (bus.s_axis_err_tvalid | (bus.s_axis_tstrb == 8'h00))
                                        : (bus.s_axis_tstrb != 8'hFF));
   assign frame_err = err_acc | beat_err;

   always_comb begin
      wr_word      = '0;
      wr_word.data = bus.s_axis_tdata[C_S_AXIS_DATA_WIDTH-1:0];
      wr_word.strb = bus.s_axis_tstrb;
      wr_word.last = bus.s_axis_tlast;
      wr_word.err  = frame_err;
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         wr_ptr      <= '0;
         frame_start <= '0;
         err_acc     <= 1'b0;
         dropping_q  <= 1'b0;
         drop_count  <= 16'd0;
         ready_en    <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            if (drop_active) begin
               wr_ptr  <= frame_start;
               err_acc <= 1'b0;
               if (bus.s_axis_tlast) begin
                  dropping_q <= 1'b0;
                  if (drop_count != 16'hFFFF) begin
                     drop_count <= drop_count + 16'd1;
                  end
               end else begin
                  dropping_q <= 1'b1;
               end
            end else begin
               wr_ptr <= wr_ptr + PTR_ONE;
               if (bus.s_axis_tlast) begin
                  frame_start <= wr_ptr + PTR_ONE;
                  err_acc     <= 1'b0;
               end else begin
                  err_acc <= frame_err;
               end
            end
         end
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         frame_count <= '0;
      end else begin
         case ({frame_inc, frame_dec})
            2'b10:   frame_count <= frame_count + PTR_ONE;
            2'b01:   frame_count <= frame_count - PTR_ONE;
            default: frame_count <= frame_count;
         endcase
      end
   end

   // Outputs are registered, so the IFG state runs two cycles shorter than the visible gap.
   // With a zero gap, STATUS fetches the next frame directly.
   always_comb begin
      state_n    = state;
      ifg_n      = ifg_cnt;
      rd_en      = 1'b0;
      frame_dec  = 1'b0;
      rx_data_n  = 64'd0;
      rx_valid_n = 8'h00;
      good_n     = 1'b0;
      bad_n      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frame_count != '0) begin
               rd_en   = 1'b1;
               state_n = ST_SEND;
            end
         end
         ST_SEND: begin
            rx_data_n  = rd_word.data;
            rx_valid_n = rd_word.last ? rd_word.strb : 8'hFF;
            if (rd_word.last) begin
               state_n = ST_STATUS;
            end else begin
               rd_en = 1'b1;
            end
         end
         ST_STATUS: begin
            good_n    = !rd_word.err;
            bad_n     = rd_word.err;
            frame_dec = 1'b1;
            if ((C_IFG_CYCLES == 0) && (frame_count > PTR_ONE)) begin
               rd_en   = 1'b1;
               state_n = ST_SEND;
            end else if (C_IFG_CYCLES <= 1) begin
               state_n = ST_IDLE;
            end else begin
               ifg_n   = 16'd0;
               state_n = ST_IFG;
            end
         end
         ST_IFG: begin
            if (ifg_cnt == IFG_LAST) begin
               state_n = ST_IDLE;
            end else begin
               ifg_n = ifg_cnt + 16'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state      <= ST_IDLE;
         rd_ptr     <= '0;
         ifg_cnt    <= 16'd0;
         rx_data_q  <= 64'd0;
         rx_valid_q <= 8'h00;
         good_q     <= 1'b0;
         bad_q      <= 1'b0;
      end else begin
         state      <= state_n;
         ifg_cnt    <= ifg_n;
         rx_data_q  <= rx_data_n;
         rx_valid_q <= rx_valid_n;
         good_q     <= good_n;
         bad_q      <= bad_n;
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   assign bus.rx_data       = rx_data_q;
   assign bus.rx_data_valid = rx_valid_q;
   assign bus.rx_good_frame = good_q;
   assign bus.rx_bad_frame  = bad_q;

endmodule

// File: tb/tb_xgmac_rx_client_emu.sv
// Bench for xgmac_rx_client_emu using a 16-word store and a 3-cycle IFG.
// Expected beats and status pulses are queued when frames are driven, then matched as the MAC side emits them.
module tb_xgmac_rx_client_emu;

   localparam int N_LOG2 = 4;
   localparam int IFG    = 3;

   logic        axi_aclk = 1'b0;
   logic        axi_resetn = 1'b0;
   logic [15:0] drop_count;

   xgmac_rx_client_emu_if bus ();

   xgmac_rx_client_emu #(
      .C_S_AXIS_DATA_WIDTH (64),
      .C_FIFO_DEPTH_LOG2   (N_LOG2),
      .C_IFG_CYCLES        (IFG)
   ) dut (
      .axi_aclk   (axi_aclk),
      .axi_resetn (axi_resetn),
      .bus        (bus),
      .drop_count (drop_count)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct {
      logic        is_status;
      logic        bad;
      logic        first;
      logic [63:0] data;
      logic [7:0]  valid;
   } exp_t;

   typedef struct {
      int          beats;
      logic [7:0]  last_strb;
      int          bad_beat;
      logic [7:0]  bad_strb;
      logic        err_flag;
      logic        exp_bad;
   } frame_vec_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   frame_vec_t vecs[7];
   frame_vec_t fv;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         last_beat_cyc = 0;
   int         last_pulse_cyc = 0;
   int         ifg_gap = -1;
   int         waits;
   int         waits2;
   int         guard;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   always @(posedge axi_aclk) cyc++;

   // Match each emitted beat and status pulse against the queue head.
   always @(negedge axi_aclk) begin
      if (axi_resetn) begin
         if (bus.rx_data_valid != 8'h00) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_beat", {56'd0, bus.rx_data_valid}, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("beat_kind", {63'd0, mon_e.is_status}, 64'd0);
               checkOutput("beat_data", bus.rx_data, mon_e.data);
               checkOutput("beat_valid", {56'd0, bus.rx_data_valid}, {56'd0, mon_e.valid});
               if (mon_e.first) begin
                  ifg_gap = cyc - last_pulse_cyc - 1;
               end else begin
                  checkOutput("beat_gap", 64'(cyc - last_beat_cyc), 64'd1);
               end
            end
            last_beat_cyc = cyc;
         end
         if (bus.rx_good_frame || bus.rx_bad_frame) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_status", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("status_kind", {63'd0, mon_e.is_status}, 64'd1);
               checkOutput("status_good_bad", {62'd0, bus.rx_good_frame, bus.rx_bad_frame},
                           mon_e.bad ? 64'd1 : 64'd2);
               checkOutput("status_latency", 64'(cyc - last_beat_cyc), 64'd1);
            end
            last_pulse_cyc = cyc;
         end
      end
   end

   task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l,
                            input logic e, output int nwait);
      bit ok;
      int g;
      nwait = 0;
      g     = 0;
      bus.s_axis_tdata      = d;
      bus.s_axis_tstrb      = s;
      bus.s_axis_tlast      = l;
      bus.s_axis_err_tvalid = e;
      bus.s_axis_tvalid     = 1'b1;
      do begin
         @(negedge axi_aclk);
         ok = bus.s_axis_tready;
         if (!ok) nwait++;
         @(posedge axi_aclk);
         #1;
         g++;
      end while (!ok && g < 500);
      if (!ok) checkOutput("tready_timeout", 64'd0, 64'd1);
   endtask

   task automatic applyStimulus(input frame_vec_t v, input bit expect_drop, output int total_wait);
      logic [63:0] d [];
      logic [7:0]  s;
      logic        l;
      int          w;
      exp_t        e;
      total_wait = 0;
      d = new[v.beats];
      for (int b = 0; b < v.beats; b++) begin
         d[b] = {$urandom(), $urandom()};
         if (!expect_drop) begin
            e.is_status = 1'b0;
            e.bad       = 1'b0;
            e.first     = (b == 0);
            e.data      = d[b];
            e.valid     = (b == v.beats - 1) ? v.last_strb : 8'hFF;
            exp_q.push_back(e);
         end
      end
      if (!expect_drop) begin
         e.is_status = 1'b1;
         e.bad       = v.exp_bad;
         e.first     = 1'b0;
         e.data      = 64'd0;
         e.valid     = 8'h00;
         exp_q.push_back(e);
      end
      for (int b = 0; b < v.beats; b++) begin
         l = (b == v.beats - 1);
         s = l ? v.last_strb : ((b == v.bad_beat) ? v.bad_strb : 8'hFF);
         send_beat(d[b], s, l, l & v.err_flag, w);
         total_wait += w;
      end
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 400) begin
         @(posedge axi_aclk);
         g++;
      end
      checkOutput(name, 64'(exp_q.size()), 64'd0);
      repeat (8) @(posedge axi_aclk);
      #1;
   endtask

   function automatic frame_vec_t good_frame(input int beats, input logic [7:0] last_strb);
      frame_vec_t v;
      v = '{beats, last_strb, -1, 8'hFF, 1'b0, 1'b0};
      return v;
   endfunction

   initial begin
      vecs[0] = '{8, 8'hFF, -1, 8'hFF, 1'b0, 1'b0};
      vecs[1] = '{8, 8'h1F, -1, 8'hFF, 1'b0, 1'b0};
      vecs[2] = '{3, 8'hFF, -1, 8'hFF, 1'b1, 1'b1};
      vecs[3] = '{4, 8'hFF,  1, 8'h0F, 1'b0, 1'b1};
      vecs[4] = '{2, 8'h05, -1, 8'hFF, 1'b0, 1'b1};
      vecs[5] = '{1, 8'h07, -1, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{5, 8'hFF,  2, 8'h7F, 1'b0, 1'b1};

      bus.s_axis_tdata      = 64'd0;
      bus.s_axis_tstrb      = 8'h00;
      bus.s_axis_tvalid     = 1'b0;
      bus.s_axis_tlast      = 1'b0;
      bus.s_axis_err_tvalid = 1'b0;

      repeat (3) @(posedge axi_aclk);
      #1;
      checkOutput("rst_rx_data", bus.rx_data, 64'd0);
      checkOutput("rst_rx_valid", {56'd0, bus.rx_data_valid}, 64'd0);
      checkOutput("rst_good", {63'd0, bus.rx_good_frame}, 64'd0);
      checkOutput("rst_bad", {63'd0, bus.rx_bad_frame}, 64'd0);
      checkOutput("rst_tready", {63'd0, bus.s_axis_tready}, 64'd0);
      checkOutput("rst_drop_count", {48'd0, drop_count}, 64'd0);
      @(negedge axi_aclk);
      axi_resetn = 1'b1;
      @(posedge axi_aclk);
      #1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i], 1'b0, waits);
         wait_drain($sformatf("drain_vec%0d", i));
      end

      // Oversized frame: dropped without backpressure, then a small frame passes intact.
      applyStimulus(good_frame(20, 8'hFF), 1'b1, waits);
      checkOutput("drop_tready_low_cycles", 64'(waits), 64'd0);
      checkOutput("drop_count", {48'd0, drop_count}, 64'd1);
      applyStimulus(good_frame(2, 8'hFF), 1'b0, waits);
      wait_drain("drain_after_drop");

      // Two frames back to back: the gap after the status pulse equals the IFG.
      ifg_gap = -1;
      applyStimulus(good_frame(4, 8'hFF), 1'b0, waits);
      applyStimulus(good_frame(3, 8'h3F), 1'b0, waits);
      wait_drain("drain_ifg");
      checkOutput("ifg_gap", 64'(ifg_gap), 64'(IFG));

      // A store filled by one frame holds off the next beat until reading starts.
      applyStimulus(good_frame(16, 8'hFF), 1'b0, waits);
      applyStimulus(good_frame(2, 8'h01), 1'b0, waits2);
      checkOutput("fill_no_wait", 64'(waits), 64'd0);
      checkOutput("full_backpressure", {63'd0, waits2 > 0}, 64'd1);
      wait_drain("drain_full");

      // Reset in the middle of SEND: outputs clear at once, and the stored frame is lost.
      applyStimulus(good_frame(8, 8'hFF), 1'b0, waits);
      guard = 0;
      while (bus.rx_data_valid == 8'h00 && guard < 100) begin
         @(negedge axi_aclk);
         guard++;
      end
      checkOutput("send_started", {63'd0, bus.rx_data_valid != 8'h00}, 64'd1);
      #2;
      axi_resetn = 1'b0;
      #1;
      checkOutput("midrst_rx_data", bus.rx_data, 64'd0);
      checkOutput("midrst_rx_valid", {56'd0, bus.rx_data_valid}, 64'd0);
      checkOutput("midrst_tready", {63'd0, bus.s_axis_tready}, 64'd0);
      checkOutput("midrst_drop_count", {48'd0, drop_count}, 64'd0);
      exp_q.delete();
      repeat (3) @(posedge axi_aclk);
      @(negedge axi_aclk);
      axi_resetn = 1'b1;
      repeat (30) @(posedge axi_aclk);
      #1;
      applyStimulus(good_frame(3, 8'h7F), 1'b0, waits);
      wait_drain("drain_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
